mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM between the CPU instruction-fetch path (requester 0) and the load/store path (requester 1).
- Sits between the lab CPU datapath and its memory.
- Latches the winning request, sequences the memory access through a 3-state FSM, and returns read data with a one-cycle ack pulse.

Parameters:
p_data_width, 16, width of memory data words
p_address_width, 10, width of memory word address
p_cnt_width, 16, width of performance counters (used only with MEM_ARB_PERF_CNT_EN)

Ports:
i_w_clk  input  1  clock, all state updates on rising edge
i_w_reset  input  1  asynchronous active-high reset
i_w_req0  input  1  requester 0 request, held until ack0
i_w_we0  input  1  requester 0 write enable (1=write, 0=read)
i_w_addr0  input  p_address_width  requester 0 address
i_w_wdata0  input  p_data_width  requester 0 write data
o_w_ack0  output  1  requester 0 completion pulse
o_w_rdata0  output  p_data_width  requester 0 read data, valid when ack0=1
i_w_req1, i_w_we1, i_w_addr1, i_w_wdata1, o_w_ack1, o_w_rdata1: same as requester 0, for requester 1
o_w_mem_cs  output  1  memory chip select
o_w_mem_we  output  1  memory write enable
o_w_mem_addr  output  p_address_width  memory address
o_w_mem_wdata  output  p_data_width  memory write data
i_w_mem_rdata  input  p_data_width  memory read data, valid the cycle after cs=1 with we=0

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - no req: stay in IDLE.
  - any req at an edge: choose a winner, latch its we/addr/wdata and winner id into registers, go to ACCESS.
- Arbitration:
  - Exactly one req high: that requester wins.
  - Both high: the requester not granted last wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- ACCESS (1 cycle):
  - o_w_mem_cs=1; mem_we/addr/wdata driven from the latched registers.
  - Next state RESP.
- RESP (1 cycle):
  - cs=0; o_w_ack<winner>=1 (decoded from state and winner id).
  - At the closing edge: for a read, i_w_mem_rdata is captured into rdata<winner>; last_grant=winner; next state IDLE.
  - o_w_rdata<n> is the captured register, or i_w_mem_rdata passed through while ack<n>=1, so data is valid in the ack cycle.
- Latency: req sampled at edge k → cs high in cycle k..k+1 → ack high in cycle k+1..k+2. Peak throughput is 1 transaction per 3 cycles.
- Requester protocol: hold req/we/addr/wdata until it samples ack=1, then deassert or present a new request.
  - Because IDLE follows RESP, a requester that drops req on the ack edge is never double-served.
- Write transactions: ack pulses; rdata<n> keeps its previous value.
- Req dropped after being latched: the transaction still completes and ack still pulses.
- At most one ack high in any cycle. ack is never high outside RESP.
- Memory outputs when not in ACCESS: cs=0, we=0. addr/wdata hold the latched values (don't-care).
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE, last_grant=1, latched regs=0, rdata0=rdata1=0.
  - Immediately forces cs=0, we=0, ack0=ack1=0.
  - An in-flight transaction is abandoned without ack.

Optional Feature:
- MEM_ARB_PERF_CNT_EN defined:
  - Adds outputs o_w_cnt0 and o_w_cnt1, p_cnt_width each.
  - Each counts completed transactions (ack pulses) of its requester.
  - Saturates at all-ones; reset to 0 by i_w_reset.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: i_w_reset=1 for 10ns, then no requests for 100ns → cs, we, ack0, ack1 stay 0; rdata0=rdata1=0.
- Single write/read, requester 1:
  - write addr 0x005, data 0xBEEF → one cs=1 cycle with we=1, addr=0x005, wdata=0xBEEF; ack1 pulses 2 cycles after req sampled.
  - read addr 0x005 → rdata1=0xBEEF while ack1=1.
- Contention: both req high continuously, reads at 0x010 (req0) and 0x020 (req1):
  - grant order 0,1,0,1.
  - each ack 3 cycles apart; never both acks high.
- Mid-flight reset: assert reset while state=ACCESS → cs drops in the same cycle; no ack; after release, the still-held req0 is served normally.
- Dropped request: req0 for 1 cycle only (read 0x003) → transaction completes; ack0 pulses once; no second access.
- MEM_ARB_PERF_CNT_EN: 5 transactions from requester 0, 3 from requester 1 → cnt0=5, cnt1=3. With p_cnt_width=2 and 5 transactions, cnt0 saturates at 3.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of the two-requester memory arbiter.
// slave: arbiter side; master: requesters plus RAM side (testbench / CPU).
interface mem_arbiter_if #(
   parameter int unsigned p_data_width    = 16,
   parameter int unsigned p_address_width = 10
);
   logic                       i_w_req0;
   logic                       i_w_we0;
   logic [p_address_width-1:0] i_w_addr0;
   logic [p_data_width-1:0]    i_w_wdata0;
   logic                       o_w_ack0;
   logic [p_data_width-1:0]    o_w_rdata0;

   logic                       i_w_req1;
   logic                       i_w_we1;
   logic [p_address_width-1:0] i_w_addr1;
   logic [p_data_width-1:0]    i_w_wdata1;
   logic                       o_w_ack1;
   logic [p_data_width-1:0]    o_w_rdata1;

   logic                       o_w_mem_cs;
   logic                       o_w_mem_we;
   logic [p_address_width-1:0] o_w_mem_addr;
   logic [p_data_width-1:0]    o_w_mem_wdata;
   logic [p_data_width-1:0]    i_w_mem_rdata;

   modport slave (
      input  i_w_req0, i_w_we0, i_w_addr0, i_w_wdata0,
      output o_w_ack0, o_w_rdata0,
      input  i_w_req1, i_w_we1, i_w_addr1, i_w_wdata1,
      output o_w_ack1, o_w_rdata1,
      output o_w_mem_cs, o_w_mem_we, o_w_mem_addr, o_w_mem_wdata,
      input  i_w_mem_rdata
   );

   modport master (
      output i_w_req0, i_w_we0, i_w_addr0, i_w_wdata0,
      input  o_w_ack0, o_w_rdata0,
      output i_w_req1, i_w_we1, i_w_addr1, i_w_wdata1,
      input  o_w_ack1, o_w_rdata1,
      input  o_w_mem_cs, o_w_mem_we, o_w_mem_addr, o_w_mem_wdata,
      output i_w_mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// Optional per-requester completion counters when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter #(
   parameter int unsigned p_data_width    = 16,
   parameter int unsigned p_address_width = 10
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   parameter int unsigned p_cnt_width     = 16
`endif
) (
   input logic          i_w_clk,
   input logic          i_w_reset,
   mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [p_cnt_width-1:0] o_w_cnt0,
   output logic [p_cnt_width-1:0] o_w_cnt1
`endif
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic                       last_grant_q, last_grant_d;
   logic                       win_q, win_d;
   logic                       we_q, we_d;
   logic [p_address_width-1:0] addr_q, addr_d;
   logic [p_data_width-1:0]    wdata_q, wdata_d;
   logic [p_data_width-1:0]    rdata0_q, rdata0_d;
   logic [p_data_width-1:0]    rdata1_q, rdata1_d;
   logic                       grant;
   logic                       ack0, ack1;

   // On a tie the requester that was not served last wins.
   assign grant = (bus.i_w_req0 & bus.i_w_req1) ? ~last_grant_q : bus.i_w_req1;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      win_d        = win_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      case (state_q)
         StIdle: begin
            if (bus.i_w_req0 | bus.i_w_req1) begin
               win_d   = grant;
               we_d    = grant ? bus.i_w_we1    : bus.i_w_we0;
               addr_d  = grant ? bus.i_w_addr1  : bus.i_w_addr0;
               wdata_d = grant ? bus.i_w_wdata1 : bus.i_w_wdata0;
               state_d = StAccess;
            end
         end
         StAccess: state_d = StResp;
         StResp: begin
            if (!we_q) begin
               if (win_q) rdata1_d = bus.i_w_mem_rdata;
               else       rdata0_d = bus.i_w_mem_rdata;
            end
            last_grant_d = win_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_w_clk or posedge i_w_reset) begin
      if (i_w_reset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         win_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         win_q        <= win_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign ack0 = (state_q == StResp) & ~win_q;
   assign ack1 = (state_q == StResp) &  win_q;

   assign bus.o_w_ack0      = ack0;
   assign bus.o_w_ack1      = ack1;
   assign bus.o_w_mem_cs    = (state_q == StAccess);
   assign bus.o_w_mem_we    = (state_q == StAccess) & we_q;
   assign bus.o_w_mem_addr  = addr_q;
   assign bus.o_w_mem_wdata = wdata_q;

   // Read data is forwarded straight from the RAM during the ack cycle.
   assign bus.o_w_rdata0 = (ack0 & ~we_q) ? bus.i_w_mem_rdata : rdata0_q;
   assign bus.o_w_rdata1 = (ack1 & ~we_q) ? bus.i_w_mem_rdata : rdata1_q;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [p_cnt_width-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge i_w_clk or posedge i_w_reset) begin
      if (i_w_reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (ack0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
         if (ack1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
      end
   end

   assign o_w_cnt0 = cnt0_q;
   assign o_w_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;
   localparam int unsigned D     = 16;
   localparam int unsigned A     = 10;
   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.p_data_width(D), .p_address_width(A)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
   logic [CNT_W-1:0] cnt0, cnt1;
   mem_arbiter #(.p_data_width(D), .p_address_width(A), .p_cnt_width(CNT_W)) dut (
      .i_w_clk(clk), .i_w_reset(rst), .bus(bus), .o_w_cnt0(cnt0), .o_w_cnt1(cnt1));
`else
   mem_arbiter #(.p_data_width(D), .p_address_width(A)) dut (
      .i_w_clk(clk), .i_w_reset(rst), .bus(bus));
`endif

   // Physical single-port RAM with one-cycle read latency.
   logic [D-1:0] ram [0:1023];
   always @(posedge clk) begin
      if (bus.o_w_mem_cs) begin
         if (bus.o_w_mem_we) ram[bus.o_w_mem_addr] <= bus.o_w_mem_wdata;
         else                bus.i_w_mem_rdata     <= ram[bus.o_w_mem_addr];
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction-level reference: one transaction at a time, cs in the cycle after
   // the sampling edge, ack one cycle later, retired at the following edge.
   int           cyc = 0;
   bit           m_act;
   int           m_start;
   bit           m_who, m_we, m_last;
   logic [A-1:0] m_addr;
   logic [D-1:0] m_wdata;
   logic [D-1:0] ref_mem [0:1023];
   logic [D-1:0] m_rd [2];
   int           m_cnt [2];
   bit           e_ack0, e_ack1;

   task automatic model_reset();
      m_act  = 1'b0;
      m_last = 1'b1;
      m_rd[0] = '0; m_rd[1] = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   task automatic model_edge();
      bit r0, r1, w;
      cyc++;
      if (rst) return;
      r0 = bus.i_w_req0;
      r1 = bus.i_w_req1;
      if (m_act) begin
         if (cyc == m_start + 2) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_rd[m_who]     = ref_mem[m_addr];
            m_last = m_who;
            m_act  = 1'b0;
            if (m_cnt[m_who] < CMAX) m_cnt[m_who]++;
         end
      end else if (r0 || r1) begin
         if (r0 && r1) w = !m_last;
         else          w = r1;
         m_act   = 1'b1;
         m_start = cyc;
         m_who   = w;
         m_we    = w ? bus.i_w_we1    : bus.i_w_we0;
         m_addr  = w ? bus.i_w_addr1  : bus.i_w_addr0;
         m_wdata = w ? bus.i_w_wdata1 : bus.i_w_wdata0;
      end
   endtask

   task automatic check_outputs();
      bit           e_cs;
      logic [D-1:0] e_rd0, e_rd1;
      e_cs   = m_act && (cyc == m_start);
      e_ack0 = m_act && (cyc == m_start + 1) && (m_who == 1'b0);
      e_ack1 = m_act && (cyc == m_start + 1) && (m_who == 1'b1);
      e_rd0  = (e_ack0 && !m_we) ? ref_mem[m_addr] : m_rd[0];
      e_rd1  = (e_ack1 && !m_we) ? ref_mem[m_addr] : m_rd[1];
      check_eq("cs", 32'(bus.o_w_mem_cs), 32'(e_cs));
      check_eq("mem_we", 32'(bus.o_w_mem_we), 32'(e_cs && m_we));
      if (e_cs) begin
         check_eq("mem_addr", 32'(bus.o_w_mem_addr), 32'(m_addr));
         if (m_we) check_eq("mem_wdata", 32'(bus.o_w_mem_wdata), 32'(m_wdata));
      end
      check_eq("ack0", 32'(bus.o_w_ack0), 32'(e_ack0));
      check_eq("ack1", 32'(bus.o_w_ack1), 32'(e_ack1));
      check_eq("one_ack", 32'(bus.o_w_ack0 & bus.o_w_ack1), 32'd0);
      check_eq("rdata0", 32'(bus.o_w_rdata0), 32'(e_rd0));
      check_eq("rdata1", 32'(bus.o_w_rdata1), 32'(e_rd1));
`ifdef MEM_ARB_PERF_CNT_EN
      check_eq("cnt0", 32'(cnt0), 32'(m_cnt[0]));
      check_eq("cnt1", 32'(cnt1), 32'(m_cnt[1]));
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic set_req(input int n, input bit r, input bit we, input logic [A-1:0] addr,
                          input logic [D-1:0] wd);
      if (n == 0) begin
         bus.i_w_req0 = r; bus.i_w_we0 = we; bus.i_w_addr0 = addr; bus.i_w_wdata0 = wd;
      end else begin
         bus.i_w_req1 = r; bus.i_w_we1 = we; bus.i_w_addr1 = addr; bus.i_w_wdata1 = wd;
      end
   endtask

   task automatic new_req(input int n);
      set_req(n, 1'b1, 1'($urandom_range(0, 1)), A'($urandom_range(0, 15)), D'($urandom));
   endtask

   task automatic drop_req(input int n);
      if (n == 0) bus.i_w_req0 = 1'b0;
      else        bus.i_w_req1 = 1'b0;
   endtask

   task automatic run_until_ack(input int n, input int bound, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         cycle();
         seen = (n == 0) ? e_ack0 : e_ack1;
      end
      if (!seen) check_eq(tag, 32'd0, 32'd1);
   endtask

   task automatic drive_random();
      bit r, ea;
      for (int n = 0; n < 2; n++) begin
         r  = (n == 0) ? bus.i_w_req0 : bus.i_w_req1;
         ea = (n == 0) ? e_ack0 : e_ack1;
         if (ea) begin
            if ($urandom_range(0, 1) == 1) new_req(n);
            else                           drop_req(n);
         end else if (!r) begin
            if ($urandom_range(0, 2) == 0) new_req(n);
         end else if (m_act && cyc == m_start && m_who == 1'(n) &&
                      $urandom_range(0, 3) == 0) begin
            drop_req(n);  // already latched: must still complete
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int start_c, nacks, ncs;
      int ack_who [$];
      int ack_cyc [$];
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      model_reset();
      rst = 1'b1;
      #10;
      check_outputs();
      #2 rst = 1'b0;

      // Idle after reset.
      repeat (10) cycle();

      // Contention: both requesters reading continuously.
      set_req(0, 1'b1, 1'b0, 10'h010, '0);
      set_req(1, 1'b1, 1'b0, 10'h020, '0);
      for (int i = 0; i < 20 && ack_who.size() < 4; i++) begin
         cycle();
         if (bus.o_w_ack0) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
         if (bus.o_w_ack1) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
      end
      drop_req(0);
      drop_req(1);
      check_eq("cont_nacks", 32'(ack_who.size()), 32'd4);
      for (int i = 0; i < ack_who.size() && i < 4; i++) begin
         check_eq("cont_order", 32'(ack_who[i]), 32'(i % 2));
         if (i > 0) check_eq("cont_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
      end
      repeat (3) cycle();

      // Requester 1 write then read-back.
      set_req(1, 1'b1, 1'b1, 10'h005, 16'hBEEF);
      start_c = cyc;
      run_until_ack(1, 10, "beef_wr_timeout");
      check_eq("beef_wr_latency", 32'(cyc - start_c), 32'd2);
      set_req(1, 1'b1, 1'b0, 10'h005, '0);
      run_until_ack(1, 10, "beef_rd_timeout");
      check_eq("beef_rd", 32'(bus.o_w_rdata1), 32'hBEEF);
      drop_req(1);
      repeat (3) cycle();
      check_eq("beef_hold", 32'(bus.o_w_rdata1), 32'hBEEF);

      // One-cycle request from requester 0 is still served exactly once.
      set_req(0, 1'b1, 1'b0, 10'h003, '0);
      cycle();
      drop_req(0);
      nacks = 0;
      ncs   = 0;
      repeat (6) begin
         cycle();
         nacks += int'(bus.o_w_ack0);
         ncs   += int'(bus.o_w_mem_cs);
      end
      check_eq("drop_acks", 32'(nacks), 32'd1);
      check_eq("drop_cs", 32'(ncs), 32'd0);

      // Reset during ACCESS: cs drops at once, no ack, held request served afterwards.
      set_req(0, 1'b1, 1'b0, 10'h005, '0);
      cycle();
      check_eq("mid_cs_before", 32'(bus.o_w_mem_cs), 32'd1);
      rst = 1'b1;
      model_reset();
      #1;
      check_eq("mid_cs_reset", 32'(bus.o_w_mem_cs), 32'd0);
      check_eq("mid_ack_reset", 32'(bus.o_w_ack0 | bus.o_w_ack1), 32'd0);
      check_eq("mid_rdata1_reset", 32'(bus.o_w_rdata1), 32'd0);
      repeat (2) cycle();
      #2 rst = 1'b0;
      run_until_ack(0, 10, "mid_timeout");
      check_eq("mid_rdata0", 32'(bus.o_w_rdata0), 32'(ref_mem[5]));
      drop_req(0);
      repeat (3) cycle();

      // Randomized traffic on a small address window so reads hit earlier writes.
      for (int i = 0; i < 4000; i++) begin
         cycle();
         drive_random();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
